// File: rtl/register_bank_pkg.sv
// Shared definitions for the register bank and its dump sequencer.
package register_bank_pkg;

  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_SEND = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/register_dump_fsm.sv
// Walks every register index once, presenting addr/data under a valid/ready handshake.
// state     | meaning
// DUMP_IDLE | waiting for a start pulse
// DUMP_SEND | presenting word at idx_q until the consumer accepts it
// DUMP_DONE | last word accepted; done pulse for one cycle
module register_dump_fsm
  import register_bank_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int LAST_IDX = NUM_REGS - 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_ready,
  input  logic [DATA_W-1:0] i_data_next,
  output logic [ADDR_W-1:0] o_idx_next,
  output logic              o_valid,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_IDX);

  dump_state_e       state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              valid_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              handshake;

  assign handshake = (state_q == DUMP_SEND) && i_ready;

  // Index the data word must reflect after this edge; the top resolves its content.
  always_comb begin
    o_idx_next = idx_q;
    if (state_q == DUMP_IDLE && i_start) begin
      o_idx_next = '0;
    end else if (handshake && idx_q != LAST) begin
      o_idx_next = idx_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        DUMP_IDLE: begin
          if (i_start) begin
            state_q <= DUMP_SEND;
            idx_q   <= o_idx_next;
            valid_q <= 1'b1;
            addr_q  <= o_idx_next;
            data_q  <= i_data_next;
          end
        end
        DUMP_SEND: begin
          if (handshake && idx_q == LAST) begin
            state_q <= DUMP_DONE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            // Refresh every cycle so a write to the shown register is tracked until accepted.
            idx_q  <= o_idx_next;
            addr_q <= o_idx_next;
            data_q <= i_data_next;
          end
        end
        DUMP_DONE: begin
          state_q <= DUMP_IDLE;
        end
        default: begin
          state_q <= DUMP_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid = valid_q;
  assign o_done  = done_q;
  assign o_addr  = addr_q;
  assign o_data  = data_q;

endmodule

// File: rtl/register_bank.sv
// CPU register file: two bypassed read ports, one gated write port, and a debug dump port.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int BITS_REGS = 5,
  parameter int REG_SIZE  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic                 i_reg_write,
  input  logic [BITS_REGS-1:0] i_write_addr,
  input  logic [REG_SIZE-1:0]  i_write_data,
  input  logic [BITS_REGS-1:0] i_read_addr_a,
  input  logic [BITS_REGS-1:0] i_read_addr_b,
  output logic [REG_SIZE-1:0]  o_data_a,
  output logic [REG_SIZE-1:0]  o_data_b,
  input  logic                 i_dump_start,
  input  logic                 i_dump_ready,
  output logic                 o_dump_valid,
  output logic [BITS_REGS-1:0] o_dump_addr,
  output logic [REG_SIZE-1:0]  o_dump_data,
  output logic                 o_dump_done
);

  localparam int N_REGS = 2 ** BITS_REGS;

  logic [REG_SIZE-1:0]  regs_q [N_REGS];
  logic                 wr_qual;
  logic [BITS_REGS-1:0] dump_idx_d;
  logic [REG_SIZE-1:0]  dump_data_d;

  // Register 0 is hardwired: never written, so it stays at its reset value of zero.
  assign wr_qual = i_reg_write && i_enable && (i_write_addr != '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_qual) begin
      regs_q[i_write_addr] <= i_write_data;
    end
  end

  always_comb begin
    o_data_a = regs_q[i_read_addr_a];
    if (i_read_addr_a == '0) begin
      o_data_a = '0;
    end else if (wr_qual && i_read_addr_a == i_write_addr) begin
      o_data_a = i_write_data;
    end
  end

  always_comb begin
    o_data_b = regs_q[i_read_addr_b];
    if (i_read_addr_b == '0) begin
      o_data_b = '0;
    end else if (wr_qual && i_read_addr_b == i_write_addr) begin
      o_data_b = i_write_data;
    end
  end

  // Content the dumped register will hold after this edge, so the dump never shows stale data.
  always_comb begin
    dump_data_d = regs_q[dump_idx_d];
    if (dump_idx_d == '0) begin
      dump_data_d = '0;
    end else if (wr_qual && dump_idx_d == i_write_addr) begin
      dump_data_d = i_write_data;
    end
  end

  register_dump_fsm #(
    .ADDR_W  (BITS_REGS),
    .DATA_W  (REG_SIZE),
    .LAST_IDX(N_REGS - 1)
  ) u_dump (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_start    (i_dump_start),
    .i_ready    (i_dump_ready),
    .i_data_next(dump_data_d),
    .o_idx_next (dump_idx_d),
    .o_valid    (o_dump_valid),
    .o_done     (o_dump_done),
    .o_addr     (o_dump_addr),
    .o_data     (o_dump_data)
  );

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed scenarios plus random traffic against a behavioural model.
module tb_register_bank;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_reg_write = 1'b0;
  logic [4:0]  i_write_addr = '0;
  logic [31:0] i_write_data = '0;
  logic [4:0]  i_read_addr_a = '0;
  logic [4:0]  i_read_addr_b = '0;
  logic [31:0] o_data_a, o_data_b;
  logic        i_dump_start = 1'b0;
  logic        i_dump_ready = 1'b0;
  logic        o_dump_valid;
  logic [4:0]  o_dump_addr;
  logic [31:0] o_dump_data;
  logic        o_dump_done;

  register_bank #(.BITS_REGS(5), .REG_SIZE(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_reg_write(i_reg_write),
    .i_write_addr(i_write_addr), .i_write_data(i_write_data),
    .i_read_addr_a(i_read_addr_a), .i_read_addr_b(i_read_addr_b),
    .o_data_a(o_data_a), .o_data_b(o_data_b),
    .i_dump_start(i_dump_start), .i_dump_ready(i_dump_ready),
    .o_dump_valid(o_dump_valid), .o_dump_addr(o_dump_addr),
    .o_dump_data(o_dump_data), .o_dump_done(o_dump_done)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  // Behavioural model: plain array of register contents plus dump progress.
  logic [31:0] m_regs [32];
  bit          m_valid = 1'b0;
  bit          m_done = 1'b0;
  int          m_idx = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (i_reg_write && i_enable && i_write_addr == a) return i_write_data;
    return m_regs[a];
  endfunction

  task automatic model_step();
    bit hs;
    bit nd;
    if (i_reset) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_valid = 1'b0;
      m_done  = 1'b0;
      m_idx   = 0;
    end else begin
      hs = m_valid && i_dump_ready;
      nd = 1'b0;
      if (!m_valid && !m_done && i_dump_start) begin
        m_valid = 1'b1;
        m_idx   = 0;
      end else if (hs) begin
        if (m_idx == 31) begin
          m_valid = 1'b0;
          nd = 1'b1;
        end else begin
          m_idx++;
        end
      end
      m_done = nd;
      if (i_reg_write && i_enable && i_write_addr != 0) m_regs[i_write_addr] = i_write_data;
    end
  endtask

  initial foreach (m_regs[i]) m_regs[i] = 32'h0;

  always @(posedge i_clk) model_step();

  always @(negedge i_clk) begin
    if (chk_on) begin
      check("rd_a", o_data_a, m_read(i_read_addr_a));
      check("rd_b", o_data_b, m_read(i_read_addr_b));
      check("dump_valid", {31'h0, o_dump_valid}, {31'h0, m_valid});
      check("dump_done", {31'h0, o_dump_done}, {31'h0, m_done});
      if (m_valid) begin
        check("dump_addr", {27'h0, o_dump_addr}, m_idx);
        check("dump_data", o_dump_data, m_regs[m_idx]);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    i_reg_write = 1'b1; i_enable = 1'b1; i_write_addr = a; i_write_data = d;
    tick();
    i_reg_write = 1'b0;
  endtask

  initial begin
    int hs_cnt;
    int cyc;
    bit found;

    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    chk_on = 1'b1;

    // Reset state
    i_read_addr_a = 5'd5;
    @(negedge i_clk);
    check("rst_valid", {31'h0, o_dump_valid}, 32'h0);
    check("rst_done", {31'h0, o_dump_done}, 32'h0);
    check("rst_addr", {27'h0, o_dump_addr}, 32'h0);
    check("rst_data", o_dump_data, 32'h0);
    check("rst_r5", o_data_a, 32'h0);
    tick();

    // Write then read r5
    wr(5'd5, 32'hDEADBEEF);
    i_read_addr_a = 5'd5;
    @(negedge i_clk);
    check("r5_read", o_data_a, 32'hDEADBEEF);
    tick();

    // Writes to r0 are dropped
    i_reg_write = 1'b1; i_enable = 1'b1; i_write_addr = 5'd0; i_write_data = 32'h1234;
    i_read_addr_a = 5'd0;
    @(negedge i_clk);
    check("r0_bypass", o_data_a, 32'h0);
    tick();
    i_reg_write = 1'b0;
    @(negedge i_clk);
    check("r0_read", o_data_a, 32'h0);
    tick();

    // Same-cycle bypass on r31
    i_reg_write = 1'b1; i_enable = 1'b1; i_write_addr = 5'd31; i_write_data = 32'hCAFE;
    i_read_addr_b = 5'd31;
    @(negedge i_clk);
    check("r31_bypass", o_data_b, 32'hCAFE);
    tick();
    i_reg_write = 1'b0;

    // Stalled pipeline: write ignored, and no bypass either
    i_reg_write = 1'b1; i_enable = 1'b0; i_write_addr = 5'd7; i_write_data = 32'h55;
    i_read_addr_a = 5'd7;
    @(negedge i_clk);
    check("r7_stall_bypass", o_data_a, 32'h0);
    tick();
    i_reg_write = 1'b0; i_enable = 1'b1;
    @(negedge i_clk);
    check("r7_stall", o_data_a, 32'h0);
    tick();

    // Full dump with r(n)=n and ready toggling
    for (int n = 1; n < 32; n++) wr(5'(n), 32'(n));
    i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
    hs_cnt = 0;
    cyc = 0;
    while (hs_cnt < 32 && cyc < 200) begin
      i_dump_ready = cyc[0];
      @(negedge i_clk);
      if (o_dump_valid && i_dump_ready) begin
        check("dump_seq_addr", {27'h0, o_dump_addr}, hs_cnt);
        check("dump_seq_data", o_dump_data, hs_cnt);
        hs_cnt++;
      end
      tick();
      cyc++;
    end
    i_dump_ready = 1'b0;
    check("dump_hs_count", hs_cnt, 32);
    @(negedge i_clk);
    check("dump_done_pulse", {31'h0, o_dump_done}, 32'h1);
    check("dump_no_33rd", {31'h0, o_dump_valid}, 32'h0);
    tick();
    @(negedge i_clk);
    check("dump_done_once", {31'h0, o_dump_done}, 32'h0);
    tick();

    // Reset in the middle of a dump at index 10
    i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
    i_dump_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (o_dump_valid && o_dump_addr == 5'd10) found = 1'b1;
      else tick();
    end
    check("reach_idx10", {31'h0, found}, 32'h1);
    check("idx10_data", o_dump_data, 32'd10);
    i_dump_ready = 1'b0;
    i_reset = 1'b1;
    i_reg_write = 1'b1; i_write_addr = 5'd3; i_write_data = 32'hFFFF;
    tick();
    i_reset = 1'b0;
    i_reg_write = 1'b0;
    @(negedge i_clk);
    check("abort_valid", {31'h0, o_dump_valid}, 32'h0);
    check("abort_addr", {27'h0, o_dump_addr}, 32'h0);
    check("abort_data", o_dump_data, 32'h0);
    for (int n = 0; n < 32; n++) begin
      i_read_addr_a = 5'(n);
      i_read_addr_b = 5'(31 - n);
      #1;
      check("abort_clear_a", o_data_a, 32'h0);
      check("abort_clear_b", o_data_b, 32'h0);
    end
    tick();

    // Random traffic, all checking by the model
    for (int c = 0; c < 4000; c++) begin
      i_reset      = ($urandom_range(0, 399) == 0);
      i_reg_write  = $urandom_range(0, 1) == 1;
      i_enable     = $urandom_range(0, 3) != 0;
      i_write_addr = 5'($urandom_range(0, 31));
      i_write_data = $urandom;
      i_read_addr_a = ($urandom_range(0, 2) == 0) ? i_write_addr : 5'($urandom_range(0, 31));
      i_read_addr_b = ($urandom_range(0, 2) == 0) ? i_write_addr : 5'($urandom_range(0, 31));
      // Keep writes aimed at the shown dump word from time to time
      if (o_dump_valid && $urandom_range(0, 3) == 0) i_write_addr = o_dump_addr;
      i_dump_start = $urandom_range(0, 19) == 0;
      i_dump_ready = $urandom_range(0, 1) == 1;
      tick();
    end
    i_reset = 1'b0; i_reg_write = 1'b0; i_dump_start = 1'b0; i_dump_ready = 1'b0;
    tick();
    @(negedge i_clk);
    #1;
    chk_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL have parameter BITS_REGS, default 5, register address width (32 registers).
REQ-002 SHALL have parameter REG_SIZE, default 32, register data width.
REQ-003 SHALL have i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have i_reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have i_enable, input, 1, pipeline step enable from the debug unit; gates pipeline writes only.
REQ-006 SHALL have i_reg_write, input, 1, write-back enable from the WB stage.
REQ-007 SHALL have i_write_addr, input, BITS_REGS, write-back destination (rd, rt, or 31 for JAL).
REQ-008 SHALL have i_write_data, input, REG_SIZE, write-back data.
REQ-009 SHALL have i_read_addr_a and i_read_addr_b, input, BITS_REGS each, rs/rt read addresses from ID.
REQ-010 SHALL have o_data_a and o_data_b, output, REG_SIZE each, read data to ID.
REQ-011 SHALL have i_dump_start, input, 1, single-cycle pulse requesting a full-bank dump.
REQ-012 SHALL have i_dump_ready, input, 1, consumer (UART debug TX) accepts the current dump word.
REQ-013 SHALL have o_dump_valid, output, 1; o_dump_addr, output, BITS_REGS; o_dump_data, output, REG_SIZE; o_dump_done, output, 1.

Function
REQ-014 SHALL write i_write_data into register i_write_addr on the rising edge when i_reg_write=1 and i_enable=1.
REQ-015 SHALL ignore writes to register 0; register 0 SHALL always read 0.
REQ-016 SHALL drive o_data_a/o_data_b combinationally from the addressed register (zero latency).
REQ-017 SHALL bypass: when a read address equals i_write_addr, is nonzero, and a write is qualified this cycle, output i_write_data instead of stored value.
REQ-018 SHALL implement dump FSM with states IDLE, SEND, DONE.
REQ-019 IDLE: o_dump_valid=0; on i_dump_start=1 SHALL load index 0 and go to SEND.
REQ-020 SEND: o_dump_valid=1, o_dump_addr=index, o_dump_data=register[index] (registered, stable while valid and not ready).
REQ-021 SEND: on i_dump_valid&&i_dump_ready handshake, SHALL increment index; after handshake at index 31 SHALL go to DONE.
REQ-022 DONE: o_dump_done=1 for exactly one cycle, then IDLE.
REQ-023 i_dump_start SHALL be ignored outside IDLE.
REQ-024 Dump SHALL proceed regardless of i_enable; a pipeline write to the register currently presented SHALL update o_dump_data the next cycle only if not yet handshaken (data shown is register content, never a torn mix).
REQ-025 Index SHALL not wrap; no 33rd word is emitted.

Reset
REQ-026 On i_reset=1 at a clock edge, all 32 registers SHALL clear to 0.
REQ-027 Reset SHALL force FSM to IDLE, index to 0, o_dump_valid=0, o_dump_done=0, o_dump_addr=0, o_dump_data=0, aborting any dump mid-operation.
REQ-028 Reset SHALL take priority over simultaneous writes and i_dump_start.

Structure
REQ-029 FSM state encodings and NUM_REGS=32 SHALL live in the shared project package/include.
REQ-030 Single module; no sub-modules required; the dump sequencer MAY be split as register_dump_fsm if reused by memory dump.

Verification
REQ-031 Reset, then write 0xDEADBEEF to r5 with enable=1 -> next cycle read_addr_a=5 gives 0xDEADBEEF.
REQ-032 Write 0x1234 to r0 -> o_data_a for addr 0 remains 0x00000000.
REQ-033 Same-cycle write 0xCAFE to r31 (JAL) with read_addr_b=31 -> o_data_b=0xCAFE in that cycle.
REQ-034 i_reg_write=1, i_enable=0, data 0x55 to r7 -> r7 stays 0.
REQ-035 Dump with ready toggling every other cycle, r(n)=n -> 32 handshakes, addr/data 0..31 in order, o_dump_done one cycle after the 32nd.
REQ-036 Assert i_reset during SEND at index 10 -> next cycle valid=0, state IDLE, all registers 0.
